lieat_ifu_ifetch_rsp: RTL

Instruction-fetch responder at the downstream end of the IFU fetch-request interface.
- Accepts one fetch PC per handshake and issues a single-beat read to instruction memory.
- Buffers the returned instruction word and presents it to the IDU.
- Discards stale responses on pipeline flush, capturing the flush-target PC even while a read is outstanding.
- Generates the fetch-handshake pulse that lets the request side advance its PC.

---
 rtl/lieat_ifu_ifetch_rsp_pkg.sv | 22 ++
 rtl/lieat_ifu_ifetch_rsp.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_ifetch_rsp_pkg.sv
// Shared IFU fetch definitions: XLEN, reset PC and the fetch-responder state encoding.
`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifu_ifetch_rsp_pkg;

    localparam int XLEN = `XLEN;
    localparam logic [XLEN-1:0] PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } ifetch_state_e;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/lieat_ifu_ifetch_rsp.sv
// IFU fetch responder: one outstanding instruction read, one-entry response buffer, flush kill.
// Optional feature: LIEAT_IFU_MISALIGN_CHK_EN answers misaligned PCs without a memory access.
module lieat_ifu_ifetch_rsp
    import lieat_ifu_ifetch_rsp_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic            req_wait,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_pc,
    output logic [31:0]     rsp_instr,
    output logic            rsp_err,
    output logic            rsp_wait,
    output logic            rsp_misalign,
    output logic            ifsh
);

    ifetch_state_e   r_state;
    ifetch_state_e   w_state_nxt;
    logic            r_kill;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_wait;
    logic            r_pend_wait;
    logic [31:0]     r_instr;
    logic            r_err;

    logic            w_accept;
    logic            w_start;
    logic            w_rsp_fire;
    logic            w_drop;
    logic            w_kill_set;
    logic            w_load;
    logic [XLEN-1:0] w_new_pc;
    logic            w_new_wait;
    logic            w_new_mis;

    assign req_ready  = flush | (r_state == ST_IDLE) | ((r_state == ST_HOLD) & rsp_ready);
    assign w_accept   = req_ready & (req_valid | flush);
    assign w_start    = w_accept & ((r_state == ST_IDLE) | (r_state == ST_HOLD));
    assign w_rsp_fire = (r_state == ST_WAIT) & mem_rsp_valid;
    // A response landing together with a flush is stale as well; drop it without arming kill.
    assign w_drop     = w_rsp_fire & (r_kill | flush);
    assign w_kill_set = flush & ((r_state == ST_ISSUE) | ((r_state == ST_WAIT) & ~mem_rsp_valid));
    assign w_load     = w_start | w_drop;
    assign w_new_pc   = (w_drop & ~flush) ? r_pend_pc   : req_pc;
    assign w_new_wait = (w_drop & ~flush) ? r_pend_wait : req_wait;

`ifdef LIEAT_IFU_MISALIGN_CHK_EN
    logic r_misalign;
    assign w_new_mis    = pc_misaligned(w_new_pc);
    assign rsp_misalign = r_misalign;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (w_load) begin
            r_misalign <= w_new_mis;
        end
    end
`else
    assign w_new_mis    = 1'b0;
    assign rsp_misalign = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_new_mis ? ST_HOLD : ST_ISSUE;
        end else begin
            case (r_state)
                ST_ISSUE: if (mem_req_ready) w_state_nxt = ST_WAIT;
                ST_WAIT:  if (mem_rsp_valid) w_state_nxt = ST_HOLD;
                ST_HOLD:  if (rsp_ready)     w_state_nxt = ST_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        mem_req_valid = (r_state == ST_ISSUE);
        rsp_valid     = (r_state == ST_HOLD) & ~flush;
        ifsh          = rsp_valid & rsp_ready;
    end

    // Kill and the pending flush target; a later flush simply overwrites the target.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_kill      <= 1'b0;
            r_pend_pc   <= PC_DEFAULT;
            r_pend_wait <= 1'b0;
        end else if (w_drop) begin
            r_kill <= 1'b0;
        end else if (w_kill_set) begin
            r_kill      <= 1'b1;
            r_pend_pc   <= req_pc;
            r_pend_wait <= req_wait;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc    <= PC_DEFAULT;
            r_wait  <= 1'b0;
            r_instr <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_pc   <= w_new_pc;
            r_wait <= w_new_wait;
            if (w_new_mis) begin
                r_instr <= '0;
                r_err   <= 1'b0;
            end
        end else if (w_rsp_fire) begin
            r_instr <= mem_rsp_data;
            r_err   <= mem_rsp_err;
        end
    end

    assign mem_req_addr = r_pc;
    assign rsp_pc       = r_pc;
    assign rsp_instr    = r_instr;
    assign rsp_err      = r_err;
    assign rsp_wait     = r_wait;

endmodule
